decode_group_stage: RTL and testbench
=====================================

Name: decode_group_stage

Overview:
- Parametrised, LANES-wide decode stage for the superscalar IITB RISC front end; sits between fetch and register read/rename.
- Latches one fetch group per accept and decodes every lane to the team's WB/Memory/EX control encoding.
- Issues the group in one or more cycles: it splits the group at intra-group RAW/WAW hazards and after control-transfer lanes.
- Provides valid/ready handshakes on both sides, flush support, and a saturating split-event counter.

Parameters:
- LANES, 2, instructions per fetch group; legal range 1..4.
- PC_W, 16, program-counter width.
- CNT_W, 16, width of split_count.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard held group; no accept in this cycle
- in_valid  in  1  fetch group present
- in_ready  out  1  stage can accept a group this cycle
- in_instr  in  16*LANES  lane k in bits [16k+15:16k]
- in_lane_valid  in  LANES  per-lane instruction valid
- in_pc  in  PC_W  PC of lane 0
- out_valid  out  1  at least one lane is issuing
- out_ready  in  1  downstream accepts the issue set
- out_lane_valid  out  LANES  issue set S
- out_pc  out  PC_W*LANES  lane k = held PC + k (mod 2^PC_W)
- out_wb  out  3*LANES  per-lane WB control
- out_mem  out  2*LANES  per-lane Memory control
- out_ex  out  4*LANES  per-lane EX control
- out_src1  out  4*LANES  per-lane source 1: bit3 = used, bits[2:0] = register
- out_src2  out  4*LANES  per-lane source 2: bit3 = used, bits[2:0] = register
- out_dest  out  3*LANES  per-lane destination register
- out_imm9  out  9*LANES  per-lane imm9 = instr[8:0]
- out_imm6  out  6*LANES  per-lane imm6 = instr[5:0]
- out_immc  out  LANES  per-lane immediate controller
- split_count  out  CNT_W  saturating count of hazard splits

Behaviour:
- Decode is combinational per lane from the held instruction. Fields are listed as WB/Mem/EX/src1/src2/dest/immc. A = instr[11:9], B = instr[8:6], C = instr[5:3].
  - 0000 ADD family: 110/00, EX = 0000 (cond 00), 0001 (cond 10), 0010 (cond 01); src1 = 1A, src2 = 1B, dest = C, immc = 0.
  - 0010 NAND family: as ADD, with EX = 0100/0101/0110.
  - cond 11 on 0000 or 0010 is illegal and decodes as default.
  - 0001 ADDI: 110/00/1011, src1 = 1A, src2 = 0B, dest = B, immc = 1.
  - 0011 LHI: 111/00/1111, src1 = 0A, src2 = 0B, dest = A, immc = 0.
  - 0100 LW: 100/10/1011, src1 = 1A, src2 = 0A, dest = B, immc = 0.
  - 0101 SW: 000/01/1011, src1 = 1A, src2 = 1B, dest = A, immc = 0.
  - 1100 BEQ: 000/00/0000, src1 = 1A, src2 = 1B, dest = A, immc = 0.
  - 1000 JAL: 101/00/0000, src1 = 0A, src2 = 0B, dest = A, immc = 1.
  - 1001 JLR: 101/00/0000, src1 = 0A, src2 = 1B, dest = A, immc = 0.
  - Default: 000/00/1111, src1 = 0A, src2 = 0B, dest = A, immc = 0.
- A lane writes a register iff WB[2] = 1. A lane is a control lane iff opcode is 1100, 1000 or 1001.
- State: holding register (instructions, PC) plus pending mask P (LANES bits).
- Issue set S is computed combinationally over pending lanes in ascending order:
  - The first pending lane always enters S.
  - Each later pending lane k enters S only if every earlier lane j already in S satisfies all of:
    - not (j writes and a used src of k equals dest_j);
    - not (j writes and k writes and dest_k == dest_j);
    - j is not a control lane.
  - Stop at the first lane that fails. Non-pending lanes are skipped and never block.
- Outputs:
  - out_valid = (P != 0); out_lane_valid = S.
  - All decoded fields of lanes not in S are driven to 0.
  - out_pc is always driven.
- Issue: when out_valid && out_ready, P <= P & ~S.
- in_ready = !flush && ((P == 0) || (out_ready && (P & ~S) == 0)).
- Accept: when in_valid && in_ready, load instr/PC and set P <= in_lane_valid. This overrides the issue update, giving back-to-back groups with no bubble. An all-zero in_lane_valid group is accepted and dropped.
- Latency: group accepted in cycle t appears on out_* in cycle t+1.
- flush: P <= 0 next cycle and no accept that cycle. flush has priority over issue and accept.
- split_count increments by 1 on each issue cycle where (P & ~S) != 0 and the first non-issued pending lane was stopped by a hazard or a control lane. It saturates at all ones.
- reset (synchronous, any cycle, including mid-split): P = 0, holding register = 0, split_count = 0. Hence out_valid = 0, all out fields 0, and in_ready = 1 in the cycle after reset deasserts.
- When out_ready = 0, P, S and all outputs hold stable.

Test Plan:
- Reset mid-split: hold a group with P = 2'b10, assert reset -> next cycle out_valid = 0, split_count = 0, in_ready = 1, all out fields 0.
- Independent pair: ADD R3 <- R1,R2 (0x0298), then NAND R6 <- R4,R5 (0x2970), out_ready = 1 -> one cycle later out_lane_valid = 11, out_ex lane0 = 0000, lane1 = 0100, out_dest = 3/6, split_count = 0, a new group accepted that same cycle.
- RAW split: lane0 ADD dest R3, lane1 ADDI src1 = R3 -> cycle 1 S = 01, in_ready = 0; cycle 2 S = 10, in_ready = 1; split_count = 1.
- Downstream stall: as the RAW case with out_ready = 0 for 3 cycles -> out_lane_valid stays 01 and P is unchanged; the split proceeds as normal after release.
- Control lane: lane0 JAL (imm controller 1, WB 101), lane1 LW -> S = 01 then 10. Repeat with flush asserted in the cycle after the JAL issues -> the LW never issues and out_valid = 0.
- Corner cases: in_lane_valid = 10 -> only lane1 issues with out_pc = in_pc + 1. Opcode 0000 with cond 11 -> WB 000, EX 1111. 2^CNT_W + 5 splits -> split_count = all ones.

Source files
------------

// File: rtl/decode_group_stage_if.sv
// Fetch-side, issue-side and flush/status signals of the decode group stage.
// The slave modport is the stage itself; the master modport is whoever drives it.
interface decode_group_stage_if #(
  parameter int LANES = 2,
  parameter int PC_W  = 16,
  parameter int CNT_W = 16
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [16*LANES-1:0]   in_instr;
  logic [LANES-1:0]      in_lane_valid;
  logic [PC_W-1:0]       in_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES-1:0]      out_lane_valid;
  logic [PC_W*LANES-1:0] out_pc;
  logic [3*LANES-1:0]    out_wb;
  logic [2*LANES-1:0]    out_mem;
  logic [4*LANES-1:0]    out_ex;
  logic [4*LANES-1:0]    out_src1;
  logic [4*LANES-1:0]    out_src2;
  logic [3*LANES-1:0]    out_dest;
  logic [9*LANES-1:0]    out_imm9;
  logic [6*LANES-1:0]    out_imm6;
  logic [LANES-1:0]      out_immc;
  logic [CNT_W-1:0]      split_count;

  modport slave (
    input  flush, in_valid, in_instr, in_lane_valid, in_pc, out_ready,
    output in_ready, out_valid, out_lane_valid, out_pc, out_wb, out_mem, out_ex,
           out_src1, out_src2, out_dest, out_imm9, out_imm6, out_immc, split_count
  );

  modport master (
    output flush, in_valid, in_instr, in_lane_valid, in_pc, out_ready,
    input  in_ready, out_valid, out_lane_valid, out_pc, out_wb, out_mem, out_ex,
           out_src1, out_src2, out_dest, out_imm9, out_imm6, out_immc, split_count
  );
endinterface

// File: rtl/decode_group_stage.sv
// Holds one fetch group, decodes every lane and issues it in one or more cycles,
// splitting at intra-group RAW/WAW hazards and after control-transfer lanes.
module decode_group_stage #(
  parameter int LANES = 2,
  parameter int PC_W  = 16,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  decode_group_stage_if.slave bus
);

  typedef struct packed {
    logic [2:0] wb;
    logic [1:0] mem;
    logic [3:0] ex;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [2:0] dest;
    logic       immc;
  } dec_t;

  logic [16*LANES-1:0] instr_q, instr_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [LANES-1:0]    pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  dec_t             dec [LANES];
  logic [LANES-1:0] ctrl;
  logic [LANES-1:0] issue;
  logic [LANES-1:0] remain;
  logic             stop;
  logic             lane_ok;
  logic             fire;
  logic             accept;

  function automatic dec_t decode(input logic [15:0] ins);
    dec_t       d;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] c;
    a = ins[11:9];
    b = ins[8:6];
    c = ins[5:3];
    d = '{wb: 3'b000, mem: 2'b00, ex: 4'b1111, src1: {1'b0, a}, src2: {1'b0, b},
          dest: a, immc: 1'b0};
    case (ins[15:12])
      4'b0000, 4'b0010: begin
        // ex[2] selects NAND; ex[1:0] is the condition code with its bits swapped
        if (ins[1:0] != 2'b11) begin
          d.wb   = 3'b110;
          d.ex   = {1'b0, ins[13], ins[0], ins[1]};
          d.src1 = {1'b1, a};
          d.src2 = {1'b1, b};
          d.dest = c;
        end
      end
      4'b0001: begin
        d.wb = 3'b110; d.ex = 4'b1011; d.src1 = {1'b1, a}; d.dest = b; d.immc = 1'b1;
      end
      4'b0011: d.wb = 3'b111;
      4'b0100: begin
        d.wb = 3'b100; d.mem = 2'b10; d.ex = 4'b1011;
        d.src1 = {1'b1, a}; d.src2 = {1'b0, a}; d.dest = b;
      end
      4'b0101: begin
        d.mem = 2'b01; d.ex = 4'b1011; d.src1 = {1'b1, a}; d.src2 = {1'b1, b};
      end
      4'b1100: begin
        d.ex = 4'b0000; d.src1 = {1'b1, a}; d.src2 = {1'b1, b};
      end
      4'b1000: begin
        d.wb = 3'b101; d.ex = 4'b0000; d.immc = 1'b1;
      end
      4'b1001: begin
        d.wb = 3'b101; d.ex = 4'b0000; d.src2 = {1'b1, b};
      end
      default: ;
    endcase
    return d;
  endfunction

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      dec[k]  = decode(instr_q[16*k +: 16]);
      ctrl[k] = (instr_q[16*k+12 +: 4] == 4'b1100) || (instr_q[16*k+12 +: 4] == 4'b1000) ||
                (instr_q[16*k+12 +: 4] == 4'b1001);
    end
  end

  // The first pending lane has no issued predecessor, so it always passes.
  always_comb begin
    issue   = '0;
    stop    = 1'b0;
    lane_ok = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (pend_q[k] && !stop) begin
        lane_ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (issue[j]) begin
            if (ctrl[j]) lane_ok = 1'b0;
            if (dec[j].wb[2] &&
                ((dec[k].src1[3] && dec[k].src1[2:0] == dec[j].dest) ||
                 (dec[k].src2[3] && dec[k].src2[2:0] == dec[j].dest) ||
                 (dec[k].wb[2] && dec[k].dest == dec[j].dest)))
              lane_ok = 1'b0;
          end
        end
        if (lane_ok) issue[k] = 1'b1;
        else         stop     = 1'b1;
      end
    end
  end

  assign remain       = pend_q & ~issue;
  assign fire         = (pend_q != '0) && bus.out_ready;
  assign bus.in_ready = !bus.flush && ((pend_q == '0) || (bus.out_ready && remain == '0));
  assign accept       = bus.in_valid && bus.in_ready;

  // A leftover after an issue can only come from a blocked lane, so it counts as a split.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      pend_d = '0;
    end else begin
      if (fire) begin
        pend_d = remain;
        if (remain != '0 && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
      if (accept) begin
        instr_d = bus.in_instr;
        pc_d    = bus.in_pc;
        pend_d  = bus.in_lane_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.out_valid      = (pend_q != '0);
    bus.out_lane_valid = issue;
    bus.split_count    = cnt_q;
    bus.out_pc         = '0;
    bus.out_wb         = '0;
    bus.out_mem        = '0;
    bus.out_ex         = '0;
    bus.out_src1       = '0;
    bus.out_src2       = '0;
    bus.out_dest       = '0;
    bus.out_imm9       = '0;
    bus.out_imm6       = '0;
    bus.out_immc       = '0;
    for (int k = 0; k < LANES; k++) begin
      bus.out_pc[PC_W*k +: PC_W] = pc_q + PC_W'(k);
      if (issue[k]) begin
        bus.out_wb[3*k +: 3]   = dec[k].wb;
        bus.out_mem[2*k +: 2]  = dec[k].mem;
        bus.out_ex[4*k +: 4]   = dec[k].ex;
        bus.out_src1[4*k +: 4] = dec[k].src1;
        bus.out_src2[4*k +: 4] = dec[k].src2;
        bus.out_dest[3*k +: 3] = dec[k].dest;
        bus.out_imm9[9*k +: 9] = instr_q[16*k +: 9];
        bus.out_imm6[6*k +: 6] = instr_q[16*k +: 6];
        bus.out_immc[k]        = dec[k].immc;
      end
    end
  end

endmodule

// File: tb/tb_decode_group_stage.sv
// Scoreboard bench: each accepted group is expanded by a reference model into its issue cycles,
// and a negedge monitor compares every presented issue set against the queue head.
module tb_decode_group_stage;
  localparam int L  = 2;
  localparam int PW = 16;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_group_stage_if #(.LANES(L), .PC_W(PW), .CNT_W(CW)) bus ();
  decode_group_stage #(.LANES(L), .PC_W(PW), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [2:0] wb;
    logic [1:0] mem;
    logic [3:0] ex;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [2:0] dst;
    logic       ic;
  } rdec_t;

  typedef struct packed {
    logic [L-1:0]    lanes;
    logic            split;
    logic [3*L-1:0]  wb;
    logic [2*L-1:0]  mem;
    logic [4*L-1:0]  ex;
    logic [4*L-1:0]  s1;
    logic [4*L-1:0]  s2;
    logic [3*L-1:0]  dst;
    logic [9*L-1:0]  i9;
    logic [6*L-1:0]  i6;
    logic [L-1:0]    ic;
    logic [PW*L-1:0] pc;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;
  logic [CW-1:0] exp_splits = '0;
  bit rand_rdy = 1'b0;
  bit force_rdy = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic rdec_t ref_dec(input logic [15:0] i);
    rdec_t r;
    logic [3:0] op;
    logic [2:0] a, b, c;
    op = i[15:12]; a = i[11:9]; b = i[8:6]; c = i[5:3];
    r.wb = 3'd0; r.mem = 2'd0; r.ex = 4'hF; r.s1 = {1'b0, a}; r.s2 = {1'b0, b}; r.dst = a; r.ic = 1'b0;
    case (op)
      4'h0, 4'h2: if (i[1:0] != 2'b11) begin
        r.wb = 3'b110;
        r.ex = ((op == 4'h2) ? 4'd4 : 4'd0) +
               ((i[1:0] == 2'b10) ? 4'd1 : (i[1:0] == 2'b01) ? 4'd2 : 4'd0);
        r.s1 = {1'b1, a}; r.s2 = {1'b1, b}; r.dst = c;
      end
      4'h1: begin r.wb = 3'b110; r.ex = 4'hB; r.s1 = {1'b1, a}; r.dst = b; r.ic = 1'b1; end
      4'h3: r.wb = 3'b111;
      4'h4: begin r.wb = 3'b100; r.mem = 2'b10; r.ex = 4'hB; r.s1 = {1'b1, a}; r.s2 = {1'b0, a}; r.dst = b; end
      4'h5: begin r.mem = 2'b01; r.ex = 4'hB; r.s1 = {1'b1, a}; r.s2 = {1'b1, b}; end
      4'hC: begin r.ex = 4'h0; r.s1 = {1'b1, a}; r.s2 = {1'b1, b}; end
      4'h8: begin r.wb = 3'b101; r.ex = 4'h0; r.ic = 1'b1; end
      4'h9: begin r.wb = 3'b101; r.ex = 4'h0; r.s2 = {1'b1, b}; end
      default: ;
    endcase
    return r;
  endfunction

  // True when an already-issued lane j prevents lane k from joining it.
  function automatic bit blocks(input rdec_t j, input logic [3:0] jop, input rdec_t k);
    bit raw, waw, ctl;
    raw = j.wb[2] && ((k.s1[3] && k.s1[2:0] == j.dst) || (k.s2[3] && k.s2[2:0] == j.dst));
    waw = j.wb[2] && k.wb[2] && (k.dst == j.dst);
    ctl = (jop == 4'hC) || (jop == 4'h8) || (jop == 4'h9);
    return raw || waw || ctl;
  endfunction

  task automatic push_group(input logic [16*L-1:0] ins, input logic [L-1:0] lv, input logic [PW-1:0] pc);
    rdec_t d[L];
    int taken[$];
    logic [L-1:0] pending, s;
    bit hit;
    exp_t e;
    pending = lv;
    for (int k = 0; k < L; k++) d[k] = ref_dec(ins[16*k +: 16]);
    while (pending != '0) begin
      taken.delete();
      for (int k = 0; k < L; k++) begin
        if (pending[k]) begin
          hit = 1'b0;
          foreach (taken[t]) if (blocks(d[taken[t]], ins[16*taken[t]+12 +: 4], d[k])) hit = 1'b1;
          if (hit) break;
          taken.push_back(k);
        end
      end
      s = '0;
      foreach (taken[t]) s[taken[t]] = 1'b1;
      e = '0;
      e.lanes = s;
      e.split = ((pending & ~s) != '0);
      for (int k = 0; k < L; k++) begin
        e.pc[PW*k +: PW] = pc + PW'(k);
        if (s[k]) begin
          e.wb[3*k +: 3] = d[k].wb;   e.mem[2*k +: 2] = d[k].mem; e.ex[4*k +: 4] = d[k].ex;
          e.s1[4*k +: 4] = d[k].s1;   e.s2[4*k +: 4] = d[k].s2;   e.dst[3*k +: 3] = d[k].dst;
          e.i9[9*k +: 9] = ins[16*k +: 9]; e.i6[6*k +: 6] = ins[16*k +: 6]; e.ic[k] = d[k].ic;
        end
      end
      pending = pending & ~s;
      sbq.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    #2;
    bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset || bus.flush) begin
      sbq.delete();
      if (reset) exp_splits = '0;
    end else if (bus.out_valid) begin
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_unexpected_issue actual=%0h required=none", bus.out_lane_valid);
      end else begin
        e = sbq[0];
        chk("lane_valid", 64'(bus.out_lane_valid), 64'(e.lanes));
        chk("wb", 64'(bus.out_wb), 64'(e.wb));
        chk("mem", 64'(bus.out_mem), 64'(e.mem));
        chk("ex", 64'(bus.out_ex), 64'(e.ex));
        chk("src1", 64'(bus.out_src1), 64'(e.s1));
        chk("src2", 64'(bus.out_src2), 64'(e.s2));
        chk("dest", 64'(bus.out_dest), 64'(e.dst));
        chk("imm9", 64'(bus.out_imm9), 64'(e.i9));
        chk("imm6", 64'(bus.out_imm6), 64'(e.i6));
        chk("immc", 64'(bus.out_immc), 64'(e.ic));
        chk("pc", 64'(bus.out_pc), 64'(e.pc));
        if (bus.out_ready) begin
          chk("split_count", 64'(bus.split_count), 64'(exp_splits));
          void'(sbq.pop_front());
          if (e.split && exp_splits != CMAX) exp_splits = exp_splits + 1'b1;
        end
      end
    end
  end

  task automatic send(input logic [16*L-1:0] ins, input logic [L-1:0] lv, input logic [PW-1:0] pc);
    bit ok;
    ok = 1'b0;
    bus.in_instr = ins; bus.in_lane_valid = lv; bus.in_pc = pc; bus.in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.in_ready && !reset) begin
        push_group(ins, lv, pc);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=no_ready required=ready");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !bus.out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d required=0", sbq.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask

  localparam logic [16*L-1:0] G_INDEP = {16'h2970, 16'h0298};
  localparam logic [16*L-1:0] G_RAW   = {16'h1701, 16'h0298};
  localparam logic [16*L-1:0] G_CTRL  = {16'h44C2, 16'h8205};

  initial begin
    logic [16*L-1:0] r_ins;
    reset = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_lane_valid = '0; bus.in_pc = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_split_count", 64'(bus.split_count), 64'd0);
    chk("rst_lane_valid", 64'(bus.out_lane_valid), 64'd0);
    @(posedge clk); #1;

    send(G_INDEP, 2'b11, 16'h0100);
    @(negedge clk);
    chk("indep_lanes", 64'(bus.out_lane_valid), 64'b11);
    chk("indep_ex", 64'(bus.out_ex), 64'h40);
    chk("indep_dest", 64'(bus.out_dest), 64'o63);
    chk("indep_in_ready", 64'(bus.in_ready), 64'd1);
    chk("indep_split_count", 64'(bus.split_count), 64'd0);
    @(posedge clk); #1;
    send(G_INDEP, 2'b11, 16'h0200);
    drain();

    send(G_RAW, 2'b11, 16'h0300);
    @(negedge clk);
    chk("raw_c1_lanes", 64'(bus.out_lane_valid), 64'b01);
    chk("raw_c1_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("raw_c2_lanes", 64'(bus.out_lane_valid), 64'b10);
    chk("raw_c2_in_ready", 64'(bus.in_ready), 64'd1);
    chk("raw_split_count", 64'(bus.split_count), 64'd1);
    drain();

    force_rdy = 1'b0;
    send(G_RAW, 2'b11, 16'h0400);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("stall_lanes", 64'(bus.out_lane_valid), 64'b01);
    end
    force_rdy = 1'b1;
    drain();

    send(G_CTRL, 2'b11, 16'h0500);
    @(negedge clk);
    chk("jal_lanes", 64'(bus.out_lane_valid), 64'b01);
    chk("jal_wb", 64'(bus.out_wb[2:0]), 64'b101);
    chk("jal_immc", 64'(bus.out_immc[0]), 64'd1);
    drain();
    send(G_CTRL, 2'b11, 16'h0600);
    @(negedge clk);
    @(posedge clk); #1;
    do_flush();
    @(negedge clk);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    drain();

    send(G_INDEP, 2'b10, 16'h1234);
    @(negedge clk);
    chk("lv10_lanes", 64'(bus.out_lane_valid), 64'b10);
    chk("lv10_pc1", 64'(bus.out_pc[2*PW-1:PW]), 64'h1235);
    drain();
    send({16'h0000, 16'h029B}, 2'b01, 16'h0700);
    @(negedge clk);
    chk("cond11_wb", 64'(bus.out_wb[2:0]), 64'd0);
    chk("cond11_ex", 64'(bus.out_ex[3:0]), 64'hF);
    drain();

    for (int n = 0; n < (1 << CW) + 5; n++) send(G_RAW, 2'b11, PW'(n));
    drain();
    chk("sat_split_count", 64'(bus.split_count), 64'(CMAX));

    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      r_ins = {$urandom, $urandom} & {16*L{1'b1}};
      send(r_ins, L'($urandom_range(0, (1 << L) - 1)), PW'($urandom));
      if ($urandom_range(0, 9) == 0) do_flush();
    end
    rand_rdy = 1'b0;
    drain();

    send(G_RAW, 2'b11, 16'h0800);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rstmid_split_count", 64'(bus.split_count), 64'd0);
    chk("rstmid_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rstmid_lanes", 64'(bus.out_lane_valid), 64'd0);
    chk("rstmid_fields", 64'(|{bus.out_wb, bus.out_mem, bus.out_ex, bus.out_src1, bus.out_src2,
                              bus.out_dest, bus.out_imm9, bus.out_imm6, bus.out_immc}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
